// File: rtl/debounce_toggle_gen.sv
// ---------------------------------------------------------------------------
// debounce_toggle_gen
//   Turns a raw, bouncing asynchronous input such as a push-button into a
//   clean debounced level. It also produces a single-cycle toggle-enable
//   pulse on each qualifying edge of that level. The input passes through a
//   2-flop synchronizer. A stability counter and a 4-state FSM then accept a
//   change only after the synchronized value has differed from the current
//   level for DEBOUNCE_CYCLES consecutive clock edges.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive differing synchronized edges needed to flip (>= 1)
//   PULSE_MODE      : "RISE", "FALL" or "BOTH"; any other value acts as "RISE"
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high
//   din   : raw asynchronous input
//   level : debounced, registered level
//   pulse : one-cycle pulse in the first cycle level shows a qualifying new value
//   busy  : high while a candidate change is being qualified
// ---------------------------------------------------------------------------
module debounce_toggle_gen #(
    parameter int    DEBOUNCE_CYCLES = 4,
    parameter string PULSE_MODE      = "RISE"
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic pulse,
    output logic busy
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Anything other than "FALL" or "BOTH" falls back to rising-edge pulses.
    localparam bit MODE_FALL = (PULSE_MODE == "FALL");
    localparam bit MODE_BOTH = (PULSE_MODE == "BOTH");
    localparam bit RISE_EN   = !MODE_FALL;
    localparam bit FALL_EN   = MODE_FALL || MODE_BOTH;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        LOW_ARM  = 2'd1,
        HIGH     = 2'd2,
        HIGH_ARM = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             rise_flip, fall_flip;

    always_comb begin
        sync1_d   = din;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        rise_flip = 1'b0;
        fall_flip = 1'b0;

        case (state_q)
            LOW: begin
                cnt_d = '0;
                if (sync2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = HIGH;
                        rise_flip = 1'b1;
                    end else begin
                        state_d = LOW_ARM;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            LOW_ARM: begin
                if (!sync2_q) begin
                    // Input fell back before qualifying: treat it as a glitch.
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HIGH;
                    cnt_d     = '0;
                    rise_flip = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = LOW;
                        fall_flip = 1'b1;
                    end else begin
                        state_d = HIGH_ARM;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            HIGH_ARM: begin
                if (sync2_q) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = LOW;
                    cnt_d     = '0;
                    fall_flip = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase

        level_d = (state_d == HIGH) || (state_d == HIGH_ARM);
        pulse_d = (rise_flip && RISE_EN) || (fall_flip && FALL_EN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= LOW;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;
    assign busy  = (state_q == LOW_ARM) || (state_q == HIGH_ARM);

endmodule

// File: tb/tb_debounce_toggle_gen.sv
module tb_debounce_toggle_gen;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic [3:0] lvl_o, pls_o, bsy_o;

    always #5 clk = ~clk;

    // Four configurations share the same stimulus.
    // 0: DC=4 RISE, 1: DC=3 BOTH, 2: DC=1 FALL, 3: DC=2 invalid mode (acts as RISE)
    debounce_toggle_gen #(.DEBOUNCE_CYCLES(4), .PULSE_MODE("RISE")) u_r (
        .clk(clk), .rst(rst), .din(din), .level(lvl_o[0]), .pulse(pls_o[0]), .busy(bsy_o[0]));
    debounce_toggle_gen #(.DEBOUNCE_CYCLES(3), .PULSE_MODE("BOTH")) u_b (
        .clk(clk), .rst(rst), .din(din), .level(lvl_o[1]), .pulse(pls_o[1]), .busy(bsy_o[1]));
    debounce_toggle_gen #(.DEBOUNCE_CYCLES(1), .PULSE_MODE("FALL")) u_f (
        .clk(clk), .rst(rst), .din(din), .level(lvl_o[2]), .pulse(pls_o[2]), .busy(bsy_o[2]));
    debounce_toggle_gen #(.DEBOUNCE_CYCLES(2), .PULSE_MODE("XYZ")) u_x (
        .clk(clk), .rst(rst), .din(din), .level(lvl_o[3]), .pulse(pls_o[3]), .busy(bsy_o[3]));

    int dcs   [4] = '{4, 3, 1, 2};
    int modes [4] = '{0, 2, 1, 0};   // 0 rise, 1 fall, 2 both

    // Reference model: din delayed by two edges, a run length of edges on which
    // the delayed input disagreed with the level, and a flip when the run hits DC.
    bit m_s1 [4];
    bit m_s2 [4];
    bit m_lvl[4];
    bit m_pls[4];
    int m_run[4];

    int errors = 0;
    int checks = 0;
    int pulse_cnt[4];
    int busy_cnt [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit d, input bit r);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pls[i] = 0; m_run[i] = 0;
            end else begin
                bit flipped;
                flipped = 0;
                if (m_s2[i] != m_lvl[i]) m_run[i]++;
                else                     m_run[i] = 0;
                if (m_run[i] == dcs[i]) begin
                    m_lvl[i] = !m_lvl[i];
                    m_run[i] = 0;
                    flipped  = 1;
                end
                m_pls[i] = flipped && ((m_lvl[i] && modes[i] != 1) || (!m_lvl[i] && modes[i] != 0));
                m_s2[i] = m_s1[i];
                m_s1[i] = d;
            end
        end
    endtask

    task automatic step(input logic d, input logic r);
        @(negedge clk);
        din = d;
        rst = r;
        @(posedge clk);
        model_edge(d, r);
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("level[%0d]", i), lvl_o[i], m_lvl[i]);
            check_eq($sformatf("pulse[%0d]", i), pls_o[i], m_pls[i]);
            check_eq($sformatf("busy[%0d]", i),  bsy_o[i], (m_run[i] > 0));
            if (pls_o[i]) pulse_cnt[i]++;
            if (bsy_o[i]) busy_cnt[i]++;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            pulse_cnt[i] = 0;
            busy_cnt[i]  = 0;
        end
    endtask

    initial begin
        int hold;
        logic rd;
        din = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pls[i] = 0; m_run[i] = 0;
        end
        clear_counts();

        // Reset held with din=1
        for (int e = 0; e < 3; e++) begin
            step(1'b1, 1'b1);
            check_eq("rst_outputs", {lvl_o[0], pls_o[0], bsy_o[0]}, 3'b000);
        end
        clear_counts();
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 1'b0);
            if (e == 5) check_eq("rst_rel_lvl_e5", lvl_o[0], 1'b0);
            if (e == 6) check_eq("rst_rel_lvl_e6", {lvl_o[0], pls_o[0]}, 2'b11);
        end
        check_eq("rst_rel_pulses", pulse_cnt[0], 1);
        for (int e = 0; e < 10; e++) step(1'b0, 1'b0);

        // Clean press
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 1'b0);
            if (e == 2) check_eq("press_busy_e2", bsy_o[0], 1'b0);
            if (e == 3) check_eq("press_busy_e3", bsy_o[0], 1'b1);
            if (e == 5) check_eq("press_lvl_e5", lvl_o[0], 1'b0);
            if (e == 6) check_eq("press_e6", {lvl_o[0], pls_o[0]}, 2'b11);
            if (e == 7) check_eq("press_pulse_e7", pls_o[0], 1'b0);
        end
        for (int e = 0; e < 10; e++) step(1'b0, 1'b0);

        // Bounce then hold
        clear_counts();
        for (int e = 0; e < 6; e++) step(e[0] ? 1'b0 : 1'b1, 1'b0);
        check_eq("bounce_no_pulse", pulse_cnt[0], 0);
        for (int e = 0; e < 14; e++) step(1'b1, 1'b0);
        check_eq("bounce_one_pulse", pulse_cnt[0], 1);
        check_eq("bounce_level", lvl_o[0], 1'b1);
        for (int e = 0; e < 10; e++) step(1'b0, 1'b0);

        // Single-cycle glitch
        clear_counts();
        step(1'b1, 1'b0);
        for (int e = 0; e < 8; e++) step(1'b0, 1'b0);
        check_eq("glitch_busy_cycles", busy_cnt[0], 1);
        check_eq("glitch_no_pulse", pulse_cnt[0], 0);
        check_eq("glitch_level", lvl_o[0], 1'b0);

        // Press and release, 10 cycles each
        clear_counts();
        for (int e = 0; e < 10; e++) step(1'b1, 1'b0);
        for (int e = 0; e < 10; e++) step(1'b0, 1'b0);
        check_eq("both_pulses", pulse_cnt[1], 2);
        check_eq("fall_pulses", pulse_cnt[2], 1);
        check_eq("rise_pulses", pulse_cnt[0], 1);
        check_eq("badmode_pulses", pulse_cnt[3], 1);

        // Reset mid-count: cnt reaches 2 after the 4th edge for DC=4
        for (int e = 0; e < 4; e++) step(1'b1, 1'b0);
        check_eq("midcnt_busy_before", bsy_o[0], 1'b1);
        step(1'b1, 1'b1);
        check_eq("midcnt_after_rst", {lvl_o[0], pls_o[0], bsy_o[0]}, 3'b000);
        for (int e = 0; e < 4; e++) step(1'b0, 1'b0);

        // DEBOUNCE_CYCLES=1 flips on the first differing synchronized edge
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_eq("dc1_lvl_e2", lvl_o[2], 1'b0);
        step(1'b1, 1'b0);
        check_eq("dc1_lvl_e3", lvl_o[2], 1'b1);
        for (int e = 0; e < 6; e++) step(1'b0, 1'b0);

        // Randomized hold lengths with occasional reset
        for (int n = 0; n < 120; n++) begin
            rd   = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
            for (int k = 0; k < hold; k++)
                step(rd, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
